// File: rtl/elevator_motion_ctrl.sv
// SCAN-policy car motion controller: latches floor requests, sequences inter-floor
// travel and door dwell with cycle counters, and reports car status downstream.
module elevator_motion_ctrl #(
    parameter int N_FLOORS      = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]  floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic                arrived
);
    localparam int TCNT_W = $clog2(TRAVEL_CYCLES);
    localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TRAVEL_LOAD = TCNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DOOR_LOAD   = DCNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPEN
    } state_t;

    state_t              state_reg, state_next;
    logic [FLOOR_W-1:0]  floor_reg, floor_next;
    logic [N_FLOORS-1:0] pending_reg, pending_next;
    logic                dir_up_reg, dir_up_next;
    logic                arrived_reg, arrived_next;
    logic [TCNT_W-1:0]   travel_cnt_reg, travel_cnt_next;
    logic [DCNT_W-1:0]   door_cnt_reg, door_cnt_next;

    logic [N_FLOORS-1:0] nxt, clr;
    logic [FLOOR_W-1:0]  floor_up, floor_dn;
    logic [N_FLOORS-1:0] idle_above_v, idle_below_v;
    logic [N_FLOORS-1:0] up_above_v, up_below_v, dn_above_v, dn_below_v;

    assign nxt      = pending_reg | req;
    assign floor_up = floor_reg + FLOOR_W'(1);
    assign floor_dn = floor_reg - FLOOR_W'(1);

    // Idle decisions look at latched requests only; arrival decisions look at the
    // live request set relative to the floor the car is arriving at.
    generate
        for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_dir
            localparam logic [FLOOR_W-1:0] IDX = FLOOR_W'(gi);
            assign idle_above_v[gi] = pending_reg[gi] && (IDX > floor_reg);
            assign idle_below_v[gi] = pending_reg[gi] && (IDX < floor_reg);
            assign up_above_v[gi]   = nxt[gi] && (IDX > floor_up);
            assign up_below_v[gi]   = nxt[gi] && (IDX < floor_up);
            assign dn_above_v[gi]   = nxt[gi] && (IDX > floor_dn);
            assign dn_below_v[gi]   = nxt[gi] && (IDX < floor_dn);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            floor_reg      <= '0;
            pending_reg    <= '0;
            dir_up_reg     <= 1'b1;
            arrived_reg    <= 1'b0;
            travel_cnt_reg <= '0;
            door_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            floor_reg      <= floor_next;
            pending_reg    <= pending_next;
            dir_up_reg     <= dir_up_next;
            arrived_reg    <= arrived_next;
            travel_cnt_reg <= travel_cnt_next;
            door_cnt_reg   <= door_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        floor_next      = floor_reg;
        dir_up_next     = dir_up_reg;
        arrived_next    = 1'b0;
        travel_cnt_next = travel_cnt_reg;
        door_cnt_next   = door_cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (pending_reg[floor_reg]) begin
                    state_next    = ST_DOOR_OPEN;
                    door_cnt_next = DOOR_LOAD;
                end else if ((|idle_above_v) && (dir_up_reg || !(|idle_below_v))) begin
                    state_next      = ST_MOVE_UP;
                    dir_up_next     = 1'b1;
                    travel_cnt_next = TRAVEL_LOAD;
                end else if (|idle_below_v) begin
                    state_next      = ST_MOVE_DOWN;
                    dir_up_next     = 1'b0;
                    travel_cnt_next = TRAVEL_LOAD;
                end
            end
            ST_MOVE_UP: begin
                if (travel_cnt_reg != '0) begin
                    travel_cnt_next = travel_cnt_reg - TCNT_W'(1);
                end else begin
                    floor_next   = floor_up;
                    arrived_next = 1'b1;
                    if (nxt[floor_up]) begin
                        state_next    = ST_DOOR_OPEN;
                        door_cnt_next = DOOR_LOAD;
                    end else if (|up_above_v) begin
                        travel_cnt_next = TRAVEL_LOAD;
                    end else if (|up_below_v) begin
                        state_next      = ST_MOVE_DOWN;
                        dir_up_next     = 1'b0;
                        travel_cnt_next = TRAVEL_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_MOVE_DOWN: begin
                if (travel_cnt_reg != '0) begin
                    travel_cnt_next = travel_cnt_reg - TCNT_W'(1);
                end else begin
                    floor_next   = floor_dn;
                    arrived_next = 1'b1;
                    if (nxt[floor_dn]) begin
                        state_next    = ST_DOOR_OPEN;
                        door_cnt_next = DOOR_LOAD;
                    end else if (|dn_below_v) begin
                        travel_cnt_next = TRAVEL_LOAD;
                    end else if (|dn_above_v) begin
                        state_next      = ST_MOVE_UP;
                        dir_up_next     = 1'b1;
                        travel_cnt_next = TRAVEL_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DOOR_OPEN: begin
                // A fresh call at this floor holds the door rather than queueing.
                if (req[floor_reg]) begin
                    door_cnt_next = DOOR_LOAD;
                end else if (door_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    door_cnt_next = door_cnt_reg - DCNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        clr = '0;
        if ((state_next == ST_DOOR_OPEN) || (state_reg == ST_DOOR_OPEN)) begin
            clr = N_FLOORS'(1) << floor_next;
        end
        pending_next = nxt & ~clr;
    end

    assign floor     = floor_reg;
    assign pending   = pending_reg;
    assign dir_up    = dir_up_reg;
    assign moving    = (state_reg == ST_MOVE_UP) || (state_reg == ST_MOVE_DOWN);
    assign door_open = (state_reg == ST_DOOR_OPEN);
    assign arrived   = arrived_reg;

endmodule

// File: doc/elevator_motion_ctrl.md
Name: elevator_motion_ctrl

Overview:
- Car-motion controller that sits directly downstream of the cabin/hall button stage.
- Consumes the per-floor request lines that stage produces, latches them into a pending bitmap, and serves them with a direction-retaining (SCAN) policy.
- Sequences travel between floors and door-open dwell using cycle counters.
- Drives floor, direction, motion and door status to the display/actuator stage.

Parameters:
- N_FLOORS, 4, number of floors served (floor indices 0..N_FLOORS-1).
- FLOOR_W, 2, width of the floor index; must satisfy 2**FLOOR_W >= N_FLOORS.
- TRAVEL_CYCLES, 8, clock cycles to travel one floor (>=2).
- DOOR_CYCLES, 4, clock cycles the door stays open (>=1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_FLOORS  request bitmap; bit i high for >=1 cycle requests floor i.
- floor  output  FLOOR_W  current car floor.
- pending  output  N_FLOORS  latched, unserved requests.
- dir_up  output  1  1 = travelling/last travelled upward.
- moving  output  1  high in MOVE_UP / MOVE_DOWN.
- door_open  output  1  high in DOOR_OPEN.
- arrived  output  1  one-cycle pulse on the cycle floor changes.

Behaviour:
- Reset (rst sampled high): state=IDLE, floor=0, pending=0, dir_up=1, moving=0, door_open=0, arrived=0, counters=0. Reset overrides everything, including mid-travel and mid-dwell.
- Definitions:
  - nxt = pending | req.
  - above = any nxt bit with index > floor.
  - below = any nxt bit with index < floor.
- Pending update each cycle: pending <= nxt & ~clr. clr is the one-hot of floor when entering DOOR_OPEN or while in DOOR_OPEN, else 0.
  - A request for the current floor during DOOR_OPEN is therefore never latched.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE decides from registered pending only, so a req pulse is acted on one cycle later. Priority:
  1. pending[floor] -> DOOR_OPEN.
  2. Else if above and (dir_up or !below) -> MOVE_UP, dir_up<=1.
  3. Else if below -> MOVE_DOWN, dir_up<=0.
  4. Else stay IDLE.
- MOVE_UP / MOVE_DOWN travel:
  - Travel counter reloads on entry and counts TRAVEL_CYCLES cycles.
  - On the last cycle: floor<=floor±1, arrived=1 for that single cycle.
  - Next state at arrival is decided with nxt evaluated at the new floor:
    1. Stop bit set -> DOOR_OPEN.
    2. Else more requests in the current direction -> same MOVE state, counter reloads.
    3. Else requests in the opposite direction -> opposite MOVE state, dir_up flips.
    4. Else IDLE.
  - floor never leaves 0..N_FLOORS-1; the above/below guards enforce this. No wrap-around.
- DOOR_OPEN:
  - door_open=1 for exactly DOOR_CYCLES cycles. pending[floor] is already 0 in the first door_open cycle.
  - A req at the current floor during dwell restarts the door counter (door_open extends).
  - After the dwell: IDLE for one cycle, then the normal IDLE decision.
- Simultaneous events:
  - A request arriving in the same cycle as arrival at that floor stops the car there.
  - Requests for other floors during any state are latched and never lost.
- Outputs:
  - moving and door_open are mutually exclusive.
  - All outputs are registered; none combinational from req.

Test Plan:
- Reset with req=0000 -> floor=0, pending=0, dir_up=1, moving=0, door_open=0, arrived=0. Holding rst high for 5 cycles with req active leaves pending=0.
- From reset, pulse req=0100 for 1 cycle -> pending=0100 next cycle; moving rises the cycle after; arrived pulses at +8 (floor=1) and +16 (floor=2); door_open high 4 cycles with pending=0000; IDLE afterward.
- Car at floor 0 moving up toward 3 (pending=1000); pulse req=0010 before reaching floor 1 -> stops at 1, door 4 cycles, resumes MOVE_UP, stops at 3; pending=0000 at end.
- Car at floor 2 with dir_up=1, pending=1001 -> serves floor 3 first, then MOVE_DOWN to floor 0 (SCAN order), dir_up=0 after reversal.
- During DOOR_OPEN at floor 1, assert req=0010 on dwell cycle 3 -> pending stays 0000; door_open extends to 3+4 total cycles from first door cycle.
- Assert rst for 1 cycle mid-travel between floors 1 and 2 (pending=0100) -> next cycle floor=0, pending=0, moving=0, state IDLE. The car stays idle until a new req.
